z_core_rf_wb_arbiter: RTL and testbench
=======================================

Name: z_core_rf_wb_arbiter

Overview:
- Shares the single write port of z_core_reg_file between two writeback requesters: A (ALU/execute) and B (load/memory).
- Holds a per-register pending-write scoreboard so the decode stage can stall on read-after-write hazards.
- Sits between the execute/memory stages and the register file. Its registered outputs drive the reg file's write_enable, rd and rd_in.

Parameters:
- XLEN, 32, data width of the register file.
- NREG, 32, number of architectural registers.
- REG_AW, 5, register index width (log2 NREG).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset: asserted when 0, clears all state immediately.
- a_valid  in  1  requester A has a writeback.
- a_ready  out  1  A's writeback is accepted this cycle.
- a_rd  in  REG_AW  A's destination register.
- a_data  in  XLEN  A's writeback value.
- b_valid, b_ready, b_rd, b_data  same widths and meaning as the A signals, for requester B.
- alloc_valid  in  1  decode issues an instruction that will write alloc_rd.
- alloc_rd  in  REG_AW  destination register to mark pending.
- rs1, rs2  in  REG_AW  source registers queried by decode.
- rs1_busy, rs2_busy  out  1  the queried register has a pending write.
- hazard  out  1  rs1_busy OR rs2_busy.
- busy_mask  out  NREG  scoreboard contents; bit 0 is always 0.
- rf_we  out  1  to reg file write_enable.
- rf_rd  out  REG_AW  to reg file rd.
- rf_rd_in  out  XLEN  to reg file rd_in.

Behaviour:
- Reset (reset=0, async): rf_we=0, rf_rd=0, rf_rd_in=0, busy_mask=0, last-grant pointer=B (so A wins the first tie). a_ready and b_ready are 0 while reset is asserted.
- Ready signals are combinational from the valids and the pointer. a_ready/b_ready never depend on the other side's ready.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: the requester NOT granted last is granted (round-robin). The pointer updates only on a grant.
  - Neither valid: no grant, pointer holds.
- Handshake: a transfer occurs on the rising edge where valid and ready are both 1. A requester must hold rd and data stable while valid=1 and ready=0. An ungranted requester keeps waiting with no loss of data.
- Output stage (latency 1):
  - A grant at edge E1 loads rf_rd/rf_rd_in.
  - rf_we=1 for exactly the cycle after E1, only if the granted rd != 0.
  - With no grant, rf_we=0 and rf_rd/rf_rd_in hold their last values.
  - The reg file commits the write at edge E2.
- Writes to x0: accepted (ready=1), rf_we stays 0, scoreboard untouched.
- Scoreboard:
  - alloc_valid with alloc_rd != 0 sets busy[alloc_rd] at the edge.
  - busy[rf_rd] clears at edge E2, the same edge at which the reg file commits.
  - rs*_busy is combinational from busy bits, so it is 1 through the rf_we cycle and 0 once the data is readable.
  - x0 is never busy.
- Simultaneous set and clear of the same register at one edge: set wins (a newer writer is pending).
- Alloc of an already-busy register: stays busy; no counting. One clear releases it.
- Both requesters valid with the same rd: both are serviced in round-robin order. Busy clears after the first commit (single-writer model; decode must not issue two writers to one rd).
- Reset mid-operation: a pending output write is dropped (rf_we forced 0) and all busy bits cleared. After release, the first tie goes to A.

Decomposition:
- Shared package z_core_pkg: XLEN, NREG, REG_AW, REG_X0 constant (0).
- One sub-module: z_core_rr_arb2, a 2-input round-robin arbiter with req[1:0] in, gnt[1:0] out, and a registered pointer with async active-low reset.
- Scoreboard and output register stay in the top module.

Test Plan:
- Reset, then a_valid=1, a_rd=5, a_data=15 for one cycle -> a_ready=1 that cycle; next cycle rf_we=1, rf_rd=5, rf_rd_in=15; then rf_we=0.
- a_valid=b_valid=1 held (a_rd=8/25, b_rd=10/30) -> A granted first, B the next cycle; rf outputs show 8/25 then 10/30 on consecutive cycles; no request lost.
- alloc_valid=1, alloc_rd=8, then rs1=8 -> rs1_busy=1 and hazard=1; after A writes x8, rs1_busy stays 1 during the rf_we cycle and is 0 on the following cycle.
- b_valid=1, b_rd=0, b_data=40 -> b_ready=1, rf_we stays 0; busy_mask[0]=0 throughout; an alloc to x0 is ignored.
- alloc_rd=10 at the same edge x10's write commits -> busy[10] remains 1.
- Assert reset=0 while rf_we=1 and busy_mask nonzero -> rf_we=0 and busy_mask=0 immediately (asynchronously); after release, simultaneous A/B requests grant A first.

Source files
------------

// File: rtl/z_core_pkg.sv
// z_core_pkg: constants and types shared by the register-file writeback arbiter.
//   XLEN   - register data width
//   NREG   - number of architectural registers
//   REG_AW - register index width (log2 NREG)
//   REG_X0 - index of the hard-wired zero register
//   rr_last_e - which requester was granted most recently
package z_core_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned REG_X0 = 0;

    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } rr_last_e;

endpackage

// File: rtl/z_core_rr_arb2.sv
// z_core_rr_arb2: two-input round-robin arbiter.
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous active-low reset (pointer returns to "B last")
//   req   in  [1:0] request vector, bit 0 = A, bit 1 = B
//   gnt   out [1:0] one-hot (or zero) grant, combinational from req and pointer
module z_core_rr_arb2
    import z_core_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    rr_last_e last_q, last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= LAST_B;
        end else begin
            last_q <= last_d;
        end
    end

    // On a tie the requester that was not granted last wins; the pointer
    // only moves when something is granted.
    always_comb begin
        gnt    = '0;
        last_d = last_q;
        if (req[0] && (!req[1] || last_q == LAST_B)) begin
            gnt[0] = 1'b1;
            last_d = LAST_A;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
            last_d = LAST_B;
        end
    end

endmodule

// File: rtl/z_core_rf_wb_arbiter.sv
// z_core_rf_wb_arbiter: shares the register-file write port between the
// execute (A) and memory (B) writeback requesters and keeps a pending-write
// scoreboard for decode hazard detection.
//   clk, reset              clock; asynchronous active-low reset
//   a_valid/a_ready/a_rd/a_data  requester A writeback handshake
//   b_valid/b_ready/b_rd/b_data  requester B writeback handshake
//   alloc_valid/alloc_rd    decode marks a destination register pending
//   rs1/rs2 -> rs1_busy/rs2_busy/hazard  decode hazard query
//   busy_mask               scoreboard contents (bit 0 always 0)
//   rf_we/rf_rd/rf_rd_in    registered write port to the register file
module z_core_rf_wb_arbiter
    import z_core_pkg::*;
#(
    parameter int unsigned XLEN   = z_core_pkg::XLEN,
    parameter int unsigned NREG   = z_core_pkg::NREG,
    parameter int unsigned REG_AW = z_core_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [REG_AW-1:0] a_rd,
    input  logic [XLEN-1:0]   a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [REG_AW-1:0] b_rd,
    input  logic [XLEN-1:0]   b_data,
    input  logic              alloc_valid,
    input  logic [REG_AW-1:0] alloc_rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              hazard,
    output logic [NREG-1:0]   busy_mask,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_rd,
    output logic [XLEN-1:0]   rf_rd_in
);

    logic [1:0]        gnt;
    logic              grant;
    logic [REG_AW-1:0] g_rd;
    logic [XLEN-1:0]   g_data;

    logic              rf_we_q,    rf_we_d;
    logic [REG_AW-1:0] rf_rd_q,    rf_rd_d;
    logic [XLEN-1:0]   rf_rd_in_q, rf_rd_in_d;
    logic [NREG-1:0]   busy_q,     busy_d;

    z_core_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (reset),
        .req   ({b_valid, a_valid}),
        .gnt   (gnt)
    );

    // Grants are masked while reset is held so no handshake completes then.
    assign a_ready = gnt[0] & reset;
    assign b_ready = gnt[1] & reset;
    assign grant   = a_ready | b_ready;
    assign g_rd    = b_ready ? b_rd   : a_rd;
    assign g_data  = b_ready ? b_data : a_data;

    always_comb begin
        rf_we_d    = grant && (g_rd != REG_AW'(REG_X0));
        rf_rd_d    = grant ? g_rd   : rf_rd_q;
        rf_rd_in_d = grant ? g_data : rf_rd_in_q;

        // Clear on commit first, then set, so a fresh allocation at the
        // commit edge keeps the register pending.
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_rd_q] = 1'b0;
        end
        if (alloc_valid && (alloc_rd != REG_AW'(REG_X0))) begin
            busy_d[alloc_rd] = 1'b1;
        end
        busy_d[REG_X0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_rd_in_q <= '0;
            busy_q     <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_rd_in_q <= rf_rd_in_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_rd     = rf_rd_q;
    assign rf_rd_in  = rf_rd_in_q;
    assign busy_mask = busy_q;
    assign rs1_busy  = busy_q[rs1];
    assign rs2_busy  = busy_q[rs2];
    assign hazard    = rs1_busy | rs2_busy;

endmodule

// File: tb/tb_z_core_rf_wb_arbiter.sv
module tb_z_core_rf_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        a_valid, b_valid, alloc_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_rd, b_rd, alloc_rd, rs1, rs2;
    logic [31:0] a_data, b_data;
    logic        rs1_busy, rs2_busy, hazard;
    logic [31:0] busy_mask;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_rd_in;

    int n_checks;
    int n_errors;

    z_core_rf_wb_arbiter #(
        .XLEN   (32),
        .NREG   (32),
        .REG_AW (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_rd        (a_rd),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_rd        (b_rd),
        .b_data      (b_data),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .hazard      (hazard),
        .busy_mask   (busy_mask),
        .rf_we       (rf_we),
        .rf_rd       (rf_rd),
        .rf_rd_in    (rf_rd_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bdat;
        logic        alv;
        logic [4:0]  alrd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_ar;
        logic        e_br;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_dat;
        logic        e_r1b;
        logic        e_r2b;
        logic [31:0] e_mask;
    } vec_t;

    vec_t tbl[7];

    // Behavioural reference: a set of pending registers, the in-flight write,
    // and whose turn it is to win a tie.
    bit          m_busy[32];
    bit          m_we;
    int unsigned m_rd;
    int unsigned m_data;
    bit          m_a_pri;
    bit          e_ar, e_br;
    bit          a_acc, b_acc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mkrow(
        input int unsigned av, ard, adat, bv, brd, bdat, alv, alrd, r1, r2,
        input int unsigned ear, ebr, ewe, erd, edat, er1b, er2b, emask);
        vec_t v;
        v.av = av[0];    v.ard = ard[4:0];   v.adat = adat;
        v.bv = bv[0];    v.brd = brd[4:0];   v.bdat = bdat;
        v.alv = alv[0];  v.alrd = alrd[4:0];
        v.r1 = r1[4:0];  v.r2 = r2[4:0];
        v.e_ar = ear[0]; v.e_br = ebr[0];    v.e_we = ewe[0];
        v.e_rd = erd[4:0]; v.e_dat = edat;
        v.e_r1b = er1b[0]; v.e_r2b = er2b[0]; v.e_mask = emask;
        return v;
    endfunction

    task automatic idle_inputs();
        a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_rd = '0; b_data = '0;
        alloc_valid = 1'b0; alloc_rd = '0; rs1 = '0; rs2 = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_we = 1'b0; m_rd = 0; m_data = 0; m_a_pri = 1'b1;
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        for (int i = 1; i < 32; i++) m[i] = m_busy[i];
        return m;
    endfunction

    task automatic model_comb();
        e_ar = a_valid && (!b_valid || m_a_pri);
        e_br = b_valid && !e_ar;
    endtask

    task automatic model_edge();
        if (m_we) m_busy[m_rd] = 1'b0;
        if (alloc_valid && alloc_rd != 0) m_busy[alloc_rd] = 1'b1;
        if (e_ar || e_br) begin
            m_rd    = e_ar ? int'(a_rd)   : int'(b_rd);
            m_data  = e_ar ? a_data : b_data;
            m_we    = (m_rd != 0);
            m_a_pri = e_br;
        end else begin
            m_we = 1'b0;
        end
    endtask

    task automatic model_check();
        chk("rnd_a_ready",  64'(a_ready),   64'(e_ar));
        chk("rnd_b_ready",  64'(b_ready),   64'(e_br));
        chk("rnd_rf_we",    64'(rf_we),     64'(m_we));
        chk("rnd_rf_rd",    64'(rf_rd),     64'(m_rd));
        chk("rnd_rf_rd_in", 64'(rf_rd_in),  64'(m_data));
        chk("rnd_busy_mask",64'(busy_mask), 64'(model_mask()));
        chk("rnd_rs1_busy", 64'(rs1_busy),  64'(m_busy[rs1] && rs1 != 0));
        chk("rnd_rs2_busy", 64'(rs2_busy),  64'(m_busy[rs2] && rs2 != 0));
        chk("rnd_hazard",   64'(hazard),
            64'((m_busy[rs1] && rs1 != 0) || (m_busy[rs2] && rs2 != 0)));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        //                av ard adat bv brd bdat alv alrd r1 r2  ar br we rd dat  r1b r2b mask
        tbl[0] = mkrow(1, 5, 15,  0, 0,  0,   0, 0,   0, 0,   1, 0, 0, 0, 0,   0, 0, 0);
        tbl[1] = mkrow(0, 0, 0,   0, 0,  0,   0, 0,   0, 0,   0, 0, 1, 5, 15,  0, 0, 0);
        tbl[2] = mkrow(0, 0, 0,   1, 0,  40,  1, 0,   0, 0,   0, 1, 0, 5, 15,  0, 0, 0);
        tbl[3] = mkrow(1, 8, 25,  1, 10, 30,  1, 8,   8, 10,  1, 0, 0, 0, 40,  0, 0, 0);
        tbl[4] = mkrow(0, 0, 0,   1, 10, 30,  1, 10,  8, 10,  0, 1, 1, 8, 25,  1, 0, 32'h100);
        tbl[5] = mkrow(0, 0, 0,   0, 0,  0,   1, 10,  8, 10,  0, 0, 1, 10, 30, 0, 1, 32'h400);
        tbl[6] = mkrow(0, 0, 0,   0, 0,  0,   0, 0,   8, 10,  0, 0, 0, 10, 30, 0, 1, 32'h400);

        // Reset state, with both requesters asking: nothing may be accepted.
        idle_inputs();
        reset = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_a_ready",  64'(a_ready),   64'd0);
        chk("rst_b_ready",  64'(b_ready),   64'd0);
        chk("rst_rf_we",    64'(rf_we),     64'd0);
        chk("rst_rf_rd",    64'(rf_rd),     64'd0);
        chk("rst_rf_rd_in", 64'(rf_rd_in),  64'd0);
        chk("rst_busy",     64'(busy_mask), 64'd0);
        idle_inputs();
        reset = 1'b1;

        // Directed vector table: one row per cycle.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a_valid = tbl[i].av; a_rd = tbl[i].ard; a_data = tbl[i].adat;
            b_valid = tbl[i].bv; b_rd = tbl[i].brd; b_data = tbl[i].bdat;
            alloc_valid = tbl[i].alv; alloc_rd = tbl[i].alrd;
            rs1 = tbl[i].r1; rs2 = tbl[i].r2;
            #1;
            chk($sformatf("vec%0d_a_ready", i),  64'(a_ready),   64'(tbl[i].e_ar));
            chk($sformatf("vec%0d_b_ready", i),  64'(b_ready),   64'(tbl[i].e_br));
            chk($sformatf("vec%0d_rf_we", i),    64'(rf_we),     64'(tbl[i].e_we));
            chk($sformatf("vec%0d_rf_rd", i),    64'(rf_rd),     64'(tbl[i].e_rd));
            chk($sformatf("vec%0d_rf_rd_in", i), 64'(rf_rd_in),  64'(tbl[i].e_dat));
            chk($sformatf("vec%0d_rs1_busy", i), 64'(rs1_busy),  64'(tbl[i].e_r1b));
            chk($sformatf("vec%0d_rs2_busy", i), 64'(rs2_busy),  64'(tbl[i].e_r2b));
            chk($sformatf("vec%0d_hazard", i),   64'(hazard),    64'(tbl[i].e_r1b | tbl[i].e_r2b));
            chk($sformatf("vec%0d_busy_mask", i),64'(busy_mask), 64'(tbl[i].e_mask));
        end

        // Reset in the middle of a pending write with busy registers.
        @(negedge clk);
        idle_inputs();
        a_valid = 1'b1; a_rd = 5'd12; a_data = 32'd77;
        alloc_valid = 1'b1; alloc_rd = 5'd12;
        #1;
        chk("mid_a_ready", 64'(a_ready), 64'd1);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("mid_rf_we",   64'(rf_we),     64'd1);
        chk("mid_busy",    64'(busy_mask), 64'h1400);
        reset = 1'b0;
        #1;
        chk("async_rf_we",    64'(rf_we),     64'd0);
        chk("async_busy",     64'(busy_mask), 64'd0);
        chk("async_rf_rd",    64'(rf_rd),     64'd0);
        chk("async_rf_rd_in", 64'(rf_rd_in),  64'd0);
        a_valid = 1'b1; a_rd = 5'd8;  a_data = 32'd25;
        b_valid = 1'b1; b_rd = 5'd10; b_data = 32'd30;
        #1;
        chk("inrst_a_ready", 64'(a_ready), 64'd0);
        chk("inrst_b_ready", 64'(b_ready), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_a_first", 64'(a_ready), 64'd1);
        chk("post_b_wait",  64'(b_ready), 64'd0);
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        chk("post_b_ready", 64'(b_ready),  64'd1);
        chk("post_we_a",    64'(rf_we),    64'd1);
        chk("post_rd_a",    64'(rf_rd),    64'd8);
        chk("post_dat_a",   64'(rf_rd_in), 64'd25);
        @(negedge clk);
        b_valid = 1'b0;
        #1;
        chk("post_we_b",  64'(rf_we),    64'd1);
        chk("post_rd_b",  64'(rf_rd),    64'd10);
        chk("post_dat_b", 64'(rf_rd_in), 64'd30);

        // Randomised traffic against the reference model.
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        model_reset();
        a_acc = 1'b0; b_acc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!a_valid || a_acc) begin
                a_valid = ($urandom_range(0, 99) < 60);
                a_rd    = 5'($urandom_range(0, 7));
                a_data  = $urandom;
            end
            if (!b_valid || b_acc) begin
                b_valid = ($urandom_range(0, 99) < 60);
                b_rd    = 5'($urandom_range(0, 7));
                b_data  = $urandom;
            end
            alloc_valid = ($urandom_range(0, 99) < 40);
            alloc_rd    = 5'($urandom_range(0, 7));
            rs1         = 5'($urandom_range(0, 7));
            rs2         = 5'($urandom_range(0, 7));
            #1;
            model_comb();
            model_check();
            a_acc = a_valid && e_ar;
            b_acc = b_valid && e_br;
            @(posedge clk);
            model_edge();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
